// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl
//   Vertical motion sequencer for the obstacle game. Runs the jump arc
//   and the pit fall once per frame tick, and owns the run/dead/restart
//   life-cycle. The renderer draws the player at ground_y - height + depth.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high
//   frame_tick   in   one-cycle pulse per video frame; motion advances on it
//   start        in   pulse; starts from IDLE, restarts from DEAD
//   jump_req     in   pulse from the debounced jump button
//   over_pit     in   level; player column is above a pit
//   hit_obstacle in   level; player sprite overlaps an obstacle
//   height       out  [9:0] offset above ground
//   depth        out  [9:0] offset below ground while falling
//   airborne     out  high in RISE or DESCEND
//   alive        out  high in RUN, RISE, DESCEND or FALL
//   game_over    out  high in DEAD
//   jump_count   out  [7:0] completed jump launches, saturating at 255
module player_motion_ctrl #(
    parameter int unsigned JUMP_STEP  = 7,
    parameter int unsigned JUMP_PEAK  = 112,
    parameter int unsigned FALL_STEP  = 20,
    parameter int unsigned FALL_LIMIT = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       jump_req,
    input  logic       over_pit,
    input  logic       hit_obstacle,
    output logic [9:0] height,
    output logic [9:0] depth,
    output logic       airborne,
    output logic       alive,
    output logic       game_over,
    output logic [7:0] jump_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_RISE,
        S_DESCEND,
        S_FALL,
        S_DEAD
    } state_t;

    localparam logic [10:0] JSTEP = 11'(JUMP_STEP);
    localparam logic [10:0] JPEAK = 11'(JUMP_PEAK);
    localparam logic [10:0] FSTEP = 11'(FALL_STEP);
    localparam logic [10:0] FLIM  = 11'(FALL_LIMIT);

    state_t      state, state_nx;
    logic [9:0]  height_nx, depth_nx;
    logic [7:0]  count_nx;
    logic        pending, pending_nx;

    // 11-bit saturating arithmetic so height/depth can never wrap.
    logic [10:0] rise_sum, rise_h, desc_h, fall_sum, fall_d;
    logic [7:0]  count_inc;

    always_comb begin
        rise_sum  = {1'b0, height} + JSTEP;
        rise_h    = (rise_sum >= JPEAK) ? JPEAK : rise_sum;
        desc_h    = ({1'b0, height} <= JSTEP) ? '0 : ({1'b0, height} - JSTEP);
        fall_sum  = {1'b0, depth} + FSTEP;
        fall_d    = (fall_sum >= FLIM) ? FLIM : fall_sum;
        count_inc = (jump_count == 8'hFF) ? jump_count : jump_count + 8'd1;
    end

    always_comb begin
        state_nx   = state;
        height_nx  = height;
        depth_nx   = depth;
        pending_nx = pending;
        count_nx   = jump_count;

        case (state)
            S_IDLE: begin
                height_nx  = '0;
                depth_nx   = '0;
                pending_nx = 1'b0;
                if (start)
                    state_nx = S_RUN;
            end

            S_RUN: begin
                if (hit_obstacle) begin
                    state_nx   = S_DEAD;
                    pending_nx = 1'b0;
                end else if (frame_tick && over_pit) begin
                    state_nx   = S_FALL;
                    height_nx  = '0;
                    depth_nx   = FSTEP[9:0];
                    pending_nx = pending | jump_req;
                end else if (frame_tick && (pending || jump_req)) begin
                    state_nx   = S_RISE;
                    height_nx  = JSTEP[9:0];
                    pending_nx = 1'b0;
                    count_nx   = count_inc;
                end else begin
                    pending_nx = pending | jump_req;
                end
            end

            S_RISE: begin
                if (hit_obstacle) begin
                    state_nx   = S_DEAD;
                    pending_nx = 1'b0;
                end else if (frame_tick) begin
                    height_nx = rise_h[9:0];
                    if (rise_h == JPEAK)
                        state_nx = S_DESCEND;
                end
            end

            S_DESCEND: begin
                if (hit_obstacle) begin
                    state_nx   = S_DEAD;
                    pending_nx = 1'b0;
                end else begin
                    // A press here is buffered and launches on the first
                    // RUN tick after landing.
                    pending_nx = pending | jump_req;
                    if (frame_tick) begin
                        height_nx = desc_h[9:0];
                        if (desc_h == '0) begin
                            if (over_pit) begin
                                state_nx = S_FALL;
                                depth_nx = '0;
                            end else begin
                                state_nx = S_RUN;
                            end
                        end
                    end
                end
            end

            S_FALL: begin
                if (hit_obstacle) begin
                    state_nx   = S_DEAD;
                    pending_nx = 1'b0;
                end else if (frame_tick) begin
                    height_nx = '0;
                    depth_nx  = fall_d[9:0];
                    if (fall_d == FLIM) begin
                        state_nx   = S_DEAD;
                        pending_nx = 1'b0;
                    end
                end
            end

            S_DEAD: begin
                // Restart outranks a coincident collision; the collision is
                // seen again from RUN on the next cycle.
                if (start) begin
                    state_nx   = S_RUN;
                    height_nx  = '0;
                    depth_nx   = '0;
                    pending_nx = 1'b0;
                    count_nx   = '0;
                end
            end

            default: begin
                state_nx   = S_IDLE;
                height_nx  = '0;
                depth_nx   = '0;
                pending_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            height     <= '0;
            depth      <= '0;
            pending    <= 1'b0;
            jump_count <= '0;
            airborne   <= 1'b0;
            alive      <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_nx;
            height     <= height_nx;
            depth      <= depth_nx;
            pending    <= pending_nx;
            jump_count <= count_nx;
            // Status flags are registered from the next state so they line
            // up with height/depth on the same edge.
            airborne   <= (state_nx == S_RISE) || (state_nx == S_DESCEND);
            alive      <= (state_nx == S_RUN)  || (state_nx == S_RISE) ||
                          (state_nx == S_DESCEND) || (state_nx == S_FALL);
            game_over  <= (state_nx == S_DEAD);
        end
    end

endmodule

// File: doc/player_motion_ctrl.md
# player_motion_ctrl

Sequences the player's vertical motion for the obstacle game. It accepts jump requests and pit and collision events, and advances a jump arc or a pit fall once per frame tick. It also owns the run, dead and restart life-cycle. It sits between the input/collision logic and the sprite renderer, which draws the player at ground_y minus `height` plus `depth`.

## Interface
Parameters:
- JUMP_STEP, 7: height change per tick while rising or descending
- JUMP_PEAK, 112: apex height; need not be a multiple of JUMP_STEP
- FALL_STEP, 20: depth increase per tick while falling into a pit
- FALL_LIMIT, 480: depth at which a fall is fatal

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame; all motion advances only on it
- start  in  1  one-cycle pulse; starts from IDLE, restarts from DEAD, ignored otherwise
- jump_req  in  1  one-cycle pulse from the debounced jump button
- over_pit  in  1  level; player column is above a pit
- hit_obstacle  in  1  level; player sprite overlaps an obstacle
- height  out  10  unsigned offset above ground
- depth  out  10  unsigned offset below ground while falling
- airborne  out  1  high in RISE or DESCEND
- alive  out  1  high in RUN, RISE, DESCEND or FALL
- game_over  out  1  high in DEAD
- jump_count  out  8  completed jump launches, saturating at 255

## Operation
- Reset values:
  - state = IDLE
  - height = 0, depth = 0
  - airborne = 0, alive = 0, game_over = 0
  - jump_count = 0
  - pending = 0
- `pending` is an internal one-bit jump buffer:
  - set by jump_req in RUN or DESCEND
  - jump_req in RISE, FALL, IDLE or DEAD is dropped
  - cleared when a jump launches, and on entry to DEAD or IDLE
- Each state's actions, evaluated on the listed event:
  - IDLE:
    - start → RUN
    - height and depth held at 0
  - RUN, on frame_tick:
    - over_pit → FALL, with depth = FALL_STEP
    - otherwise (pending or jump_req) → RISE, with height = JUMP_STEP, pending cleared, jump_count incremented
  - RISE, on tick:
    - height = min(height + JUMP_STEP, JUMP_PEAK)
    - if the new height equals JUMP_PEAK → DESCEND
  - DESCEND, on tick:
    - height = (height <= JUMP_STEP) ? 0 : height − JUMP_STEP
    - when the new height is 0, go to RUN, or to FALL (depth = 0) if over_pit is high on that tick
  - FALL, on tick:
    - depth = min(depth + FALL_STEP, FALL_LIMIT)
    - when the new depth equals FALL_LIMIT → DEAD
    - height stays 0
  - DEAD:
    - height and depth frozen at their last values
    - start → RUN, with height = 0, depth = 0, pending = 0, jump_count = 0
- Collision:
  - hit_obstacle high in RUN, RISE, DESCEND or FALL → DEAD on that clock, regardless of frame_tick.
  - Collision takes priority over any tick update in the same cycle: height and depth are not updated.
- Arithmetic:
  - height and depth are computed in 11 bits and saturate as above.
  - They never wrap.
- Pit landing: over_pit is sampled only in RUN ticks and on the landing tick. A jump clears a pit if over_pit is low on the landing tick.

## Timing
- Fully registered. Every output changes on the clk edge that samples the triggering input, so it is visible one cycle after the event.
- Jump latency:
  - a jump_req coincident with a RUN tick launches on that edge
  - otherwise it launches on the next tick
- Arc with defaults:
  - 16 rise ticks (7, 14, …, 112)
  - 16 descend ticks (105, …, 0)
  - RUN after tick 32 from launch
- Early landing: a jump pressed during DESCEND launches on the first RUN tick after landing, i.e. one tick of ground contact.
- Fall with defaults: depth 20, 40, …, 480; DEAD after 24 ticks.
- Reset mid-arc or mid-fall returns to IDLE asynchronously with all reset values.
- start asserted together with hit_obstacle in DEAD: the restart wins, and the collision is evaluated from RUN on the following cycle.

## Test plan
- Reset, start, jump_req in RUN with no tick → height 0 until the next tick. Then height 7, airborne = 1, jump_count = 1. Height 112 on tick 16, 0 on tick 32, state RUN.
- JUMP_PEAK = 110, JUMP_STEP = 7 → height saturates 105 → 110, then descends 103, …, 5, 0. No underflow and no wrap.
- jump_req during RISE → dropped, with exactly one arc. jump_req during DESCEND → RISE launches on the first tick after landing, and jump_count = 2.
- over_pit high in RUN on a tick → depth 20, 40, …, 480, then game_over = 1 and alive = 0. over_pit high only on the landing tick of a jump → FALL.
- hit_obstacle at height 56 in the same cycle as frame_tick → DEAD with height frozen at 56. A start pulse → RUN with height 0, depth 0, jump_count 0.
- reset asserted mid-fall at depth 200 → all outputs at reset values immediately. A start afterwards → alive = 1.
